// File: rtl/branch_predictor.sv
// Purpose : bimodal branch predictor, 2-bit saturating counters indexed by pc[IDX_W+1:2].
// Latency : prediction 1 cycle (registered); update outcome/mispredict combinational, commit at edge.
// Backpressure: none; ready=0 during the post-reset table sweep, queries ignored and updates dropped.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   ready                         table initialised, queries/updates accepted
//   pred_valid, pred_pc           fetch query
//   pred_out_valid, pred_taken    registered prediction (counter MSB)
//   upd_valid, upd_pc, upd_funct3 stage-2 resolution of a conditional branch
//   upd_eq, upd_lt                comparator results (signedness chosen upstream)
//   upd_pred_taken                prediction originally issued for the branch
//   upd_taken, upd_mispredict     resolved direction and mispredict flag
//   branch_count, mispred_count   wrapping statistics counters
module branch_predictor #(
  parameter int unsigned ENTRIES  = 32,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ready,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        pred_out_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [2:0]  upd_funct3,
  input  logic        upd_eq,
  input  logic        upd_lt,
  input  logic        upd_pred_taken,
  output logic        upd_taken,
  output logic        upd_mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [1:0]       cnt_tbl [ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_legal;
  logic             upd_accept;
  logic [1:0]       upd_cnt;
  logic [1:0]       upd_cnt_next;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;
  logic             pred_accept;

  // Word-aligned PCs: the two low bits and everything above the index are ignored.
  assign pred_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

  assign ready = (state_q == ST_READY);

  // Next-state: the sweep pointer walks every entry once, then hands over to READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(ENTRIES - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Direction decode; funct3 010/011 are not branches and never touch state.
  always_comb begin
    upd_legal = 1'b1;
    upd_taken = 1'b0;
    case (upd_funct3)
      3'b000:         upd_taken = upd_eq;
      3'b001:         upd_taken = ~upd_eq;
      3'b100, 3'b110: upd_taken = upd_lt;
      3'b101, 3'b111: upd_taken = ~upd_lt;
      default:        upd_legal = 1'b0;
    endcase
  end

  assign upd_accept     = upd_valid & ready & upd_legal;
  assign upd_mispredict = upd_accept & (upd_taken != upd_pred_taken);
  assign pred_accept    = pred_valid & ready;

  // Saturating step; never wraps past 11 or 00.
  assign upd_cnt = cnt_tbl[upd_idx];
  always_comb begin
    upd_cnt_next = upd_cnt;
    if (upd_taken) begin
      if (upd_cnt != 2'b11) upd_cnt_next = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) upd_cnt_next = upd_cnt - 2'd1;
    end
  end

  // Single table write port shared by the init sweep and resolved updates;
  // the two never coincide because updates need ready.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = upd_idx;
    tbl_wdata = upd_cnt_next;
    if (reset_n) begin
      if (state_q == ST_INIT) begin
        tbl_we    = 1'b1;
        tbl_waddr = ptr_q;
        tbl_wdata = CNT_INIT;
      end else if (upd_accept) begin
        tbl_we = 1'b1;
      end
    end
  end

  // Table is not reset; the sweep initialises it. A same-cycle query reads
  // the pre-update value because the read below samples before this commit.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      cnt_tbl[tbl_waddr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_INIT;
      ptr_q          <= '0;
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      branch_count   <= '0;
      mispred_count  <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      pred_out_valid <= pred_accept;
      pred_taken     <= pred_accept ? cnt_tbl[pred_idx][1] : 1'b0;
      if (upd_accept) begin
        branch_count <= branch_count + 32'd1;
      end
      if (upd_mispredict) begin
        mispred_count <= mispred_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ready;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_out_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_funct3;
  logic        upd_eq;
  logic        upd_lt;
  logic        upd_pred_taken;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected prediction for every accepted query, oldest first.
  bit sb_q[$];
  bit mon_exp;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ready          (ready),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .pred_taken     (pred_taken),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_funct3     (upd_funct3),
    .upd_eq         (upd_eq),
    .upd_lt         (upd_lt),
    .upd_pred_taken (upd_pred_taken),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .branch_count   (branch_count),
    .mispred_count  (mispred_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented prediction must match the oldest pending expectation.
  always @(negedge clk) begin
    if (pred_out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pred: got pred_out_valid=1, expected no pending query");
      end else begin
        mon_exp = sb_q.pop_front();
        check("pred_taken", 32'(pred_taken), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input logic [31:0] pc, input bit exp);
    pred_valid = 1'b1;
    pred_pc    = pc;
    sb_q.push_back(exp);
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic update(input string name, input logic [31:0] pc, input logic [2:0] f3,
                        input logic eq, input logic lt, input logic ptk,
                        input logic exp_tk, input logic exp_mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_funct3     = f3;
    upd_eq         = eq;
    upd_lt         = lt;
    upd_pred_taken = ptk;
    @(negedge clk);
    check({name, "_taken"}, 32'(upd_taken), 32'(exp_tk));
    check({name, "_mispredict"}, 32'(upd_mispredict), 32'(exp_mis));
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic check_counts(input string name, input int br, input int mis);
    check({name, "_branch_count"}, branch_count, 32'(br));
    check({name, "_mispred_count"}, mispred_count, 32'(mis));
  endtask

  // Called right after reset_n is released; ready must rise on the 32nd edge.
  // A query and a legal update are driven mid-sweep and must be ignored.
  task automatic sweep(input string name);
    for (int c = 1; c <= 32; c++) begin
      tick();
      check({name, "_ready"}, 32'(ready), 32'(c == 32));
      if (c == 3) begin
        pred_valid     = 1'b1;
        pred_pc        = 32'h40;
        upd_valid      = 1'b1;
        upd_pc         = 32'h40;
        upd_funct3     = 3'b000;
        upd_eq         = 1'b1;
        upd_lt         = 1'b0;
        upd_pred_taken = 1'b0;
        #1;
        check({name, "_init_upd_mispredict"}, 32'(upd_mispredict), 32'd0);
      end
      if (c == 4) begin
        check({name, "_init_pred_out_valid"}, 32'(pred_out_valid), 32'd0);
        check_counts({name, "_init"}, 0, 0);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    pred_valid     = 1'b0;
    pred_pc        = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_funct3     = '0;
    upd_eq         = 1'b0;
    upd_lt         = 1'b0;
    upd_pred_taken = 1'b0;

    repeat (3) tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_pred_out_valid", 32'(pred_out_valid), 32'd0);
    check_counts("rst", 0, 0);

    reset_n = 1'b1;
    sweep("sweep1");

    // Cold entry (01) predicts not-taken.
    query(32'h40, 1'b0);

    // 01 -> 10 (mispredicted), 10 -> 11.
    update("beq1", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    update("beq2", 32'h40, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    query(32'h40, 1'b1);
    check_counts("train", 2, 1);

    // Three more taken at 11 saturate; one not-taken leaves 10, still taken.
    update("bne_t",  32'h40, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    update("blt_t",  32'h40, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    update("bltu_t", 32'h40, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    update("bge_nt", 32'h40, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    query(32'h40, 1'b1);
    check_counts("sat_hi", 6, 2);

    // 0xC0 aliases idx 16: 10 -> 01 flips the 0x40 prediction; pc[1:0] ignored.
    update("alias", 32'hC0, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    query(32'h40, 1'b0);
    query(32'h43, 1'b0);
    check_counts("alias", 7, 3);

    // Same-cycle query and update on idx 5: query sees 01, update commits 10.
    pred_valid = 1'b1;
    pred_pc    = 32'h14;
    sb_q.push_back(1'b0);
    update("rbw", 32'h14, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    pred_valid = 1'b0;
    query(32'h14, 1'b1);
    check_counts("rbw", 8, 4);

    // Illegal funct3: no direction, no mispredict, no state change.
    update("ill010", 32'h14, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    update("ill011", 32'h14, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    query(32'h14, 1'b1);
    check_counts("illegal", 8, 4);

    // Low saturation at idx 0: 01 -> 00 -> 00 -> 01, predicts not-taken.
    update("bne_nt1", 32'h100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    update("bne_nt2", 32'h100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    update("beq_t",   32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    query(32'h100, 1'b0);
    check_counts("sat_lo", 11, 5);

    // Mid-run reset clears counts and repeats the full sweep.
    reset_n = 1'b0;
    tick();
    check("mid_rst_ready", 32'(ready), 32'd0);
    check_counts("mid_rst", 0, 0);
    reset_n = 1'b1;
    repeat (10) tick();
    // Reset again mid-sweep: the sweep restarts from entry 0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sweep("sweep2");
    query(32'h14, 1'b0);
    query(32'h40, 1'b0);
    check_counts("post_sweep", 0, 0);

    repeat (2) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
